// File: rtl/riscv_core.sv
// Single-cycle RV32I subset core: fetch, decode, execute and writeback all in one clock.
// Supports add/sub/and/or/srl, addi/andi/ori, lb, sb and beq; every other encoding retires as a NOP.

module riscv_regfile (
  input  logic        clk,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] regs [0:31];

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs[ra2_i];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != 5'd0)) regs[wa_i] <= wd_i;
  end
endmodule

module riscv_dmem #(
  parameter int DMEM_BYTES = 128,
  parameter int AW         = $clog2(DMEM_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output logic [7:0]    rdata_o,
  input  logic          we_i,
  input  logic [7:0]    wdata_i
);
  logic [7:0] mem [0:DMEM_BYTES-1];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end
endmodule

module riscv_imem #(
  parameter int IMEM_WORDS = 64,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);
  logic [31:0] mem [0:IMEM_WORDS-1];

  assign rdata_o = mem[addr_i];

  // Write port exists only so a loader can be attached; the core ties it off.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
endmodule

module riscv_core #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  output logic [31:0] instr
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_BYTES);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0]    pc_q, pc_d;
  logic [31:0]    rs1_v, rs2_v;
  logic [31:0]    imm_i, imm_s, imm_b, ls_addr;
  logic [31:0]    rf_wd;
  logic           rf_we, dm_we;
  logic [7:0]     dm_rdata;
  logic [DAW-1:0] dm_idx;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign ls_addr = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dm_idx  = DAW'(ls_addr % DMEM_BYTES);
  assign pc_out  = pc_q;

  riscv_imem #(.IMEM_WORDS(IMEM_WORDS)) instmemo (
    .clk     (clk),
    .addr_i  (pc_q[IAW+1:2]),
    .rdata_o (instr),
    .we_i    (1'b0),
    .waddr_i ('0),
    .wdata_i (32'd0)
  );

  riscv_regfile regs (
    .clk   (clk),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rs1_v),
    .rd2_o (rs2_v),
    .we_i  (rf_we),
    .wa_i  (rd),
    .wd_i  (rf_wd)
  );

  riscv_dmem #(.DMEM_BYTES(DMEM_BYTES)) datamem (
    .clk     (clk),
    .addr_i  (dm_idx),
    .rdata_o (dm_rdata),
    .we_i    (dm_we),
    .wdata_i (rs2_v[7:0])
  );

  always_comb begin
    pc_d  = pc_q + 32'd4;
    rf_we = 1'b0;
    rf_wd = 32'd0;
    dm_we = 1'b0;
    unique case (opcode)
      OP_R: begin
        rf_we = 1'b1;
        unique case ({funct7, funct3})
          {7'h00, 3'b000}: rf_wd = rs1_v + rs2_v;
          {7'h20, 3'b000}: rf_wd = rs1_v - rs2_v;
          {7'h00, 3'b111}: rf_wd = rs1_v & rs2_v;
          {7'h00, 3'b110}: rf_wd = rs1_v | rs2_v;
          {7'h00, 3'b101}: rf_wd = rs1_v >> rs2_v[4:0];
          default:         rf_we = 1'b0;
        endcase
      end
      OP_I: begin
        rf_we = 1'b1;
        unique case (funct3)
          3'b000:  rf_wd = rs1_v + imm_i;
          3'b111:  rf_wd = rs1_v & imm_i;
          3'b110:  rf_wd = rs1_v | imm_i;
          default: rf_we = 1'b0;
        endcase
      end
      OP_LOAD: begin
        rf_we = (funct3 == 3'b000);
        rf_wd = {{24{dm_rdata[7]}}, dm_rdata};
      end
      OP_STORE:  dm_we = (funct3 == 3'b000);
      OP_BRANCH: if (funct3 == 3'b000 && rs1_v == rs2_v) pc_d = pc_q + imm_b;
      default: ;
    endcase
    // A reset edge discards whatever instruction is in flight.
    if (!reset) begin
      rf_we = 1'b0;
      dm_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= 32'd0;
    else        pc_q <= pc_d;
  end
endmodule

// File: tb/tb_riscv_core.sv
// Scoreboard bench for riscv_core: stimulus queues expected pc/instr per cycle, a monitor pops and compares.
// Final architectural state (regs, data memory) is checked against hand-computed values.

module tb_riscv_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_out, instr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] prog [0:63];

  riscv_core dut (
    .clk    (clk),
    .reset  (reset),
    .pc_out (pc_out),
    .instr  (instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_pc(input logic [31:0] p);
    exp_t e;
    e.pc  = p;
    e.ins = prog[p[7:2]];
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 60 && sb_q.size() > 0; c++) @(negedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected cycles never observed, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: the core retires one instruction per cycle, so every cycle is an output.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("instr", instr, e.ins);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
    prog[0]  = 32'h0000_0283; // lb   x5,0(x0)
    prog[1]  = 32'h0010_0503; // lb   x10,1(x0)
    prog[2]  = 32'h4020_8333; // sub  x6,x1,x2
    prog[3]  = 32'h0013_73B3; // and  x7,x6,x1
    prog[4]  = 32'h0F00_6413; // ori  x8,x0,0xF0
    prog[5]  = 32'h00F1_D4B3; // srl  x9,x3,x15
    prog[6]  = 32'h0040_0223; // sb   x4,4(x0)
    prog[7]  = 32'h0040_0583; // lb   x11,4(x0)
    prog[8]  = 32'h0050_0013; // addi x0,x0,5
    prog[9]  = 32'h0000_0633; // add  x12,x0,x0
    prog[10] = 32'h0020_8463; // beq  x1,x2,+8 (taken)
    prog[11] = 32'h0010_0693; // addi x13,x0,1 (skipped)
    prog[12] = 32'h0030_8463; // beq  x1,x3,+8 (not taken)
    prog[13] = 32'h0070_0713; // addi x14,x0,7
    prog[14] = 32'h0020_C833; // xor  x16,x1,x2 (unsupported -> NOP)
    prog[15] = 32'h0000_0063; // beq  x0,x0,0 (spin)

    for (int i = 0; i < 64; i++)  dut.instmemo.mem[i] = prog[i];
    for (int i = 0; i < 32; i++)  dut.regs.regs[i] = 32'd0;
    for (int i = 0; i < 128; i++) dut.datamem.mem[i] = 8'h00;
    dut.regs.regs[1]  = 32'd5;
    dut.regs.regs[2]  = 32'd5;
    dut.regs.regs[3]  = 32'h0000_000C;
    dut.regs.regs[4]  = 32'h0000_010F;
    dut.regs.regs[13] = 32'h0000_0055;
    dut.regs.regs[14] = 32'h0000_0066;
    dut.regs.regs[15] = 32'd2;
    dut.regs.regs[16] = 32'h0000_0077;
    dut.datamem.mem[0] = 8'h07;
    dut.datamem.mem[1] = 8'hF0;
    dut.datamem.mem[5] = 8'hAA;

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc_out, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a <= 32'h28; a += 4) push_pc(a);
    push_pc(32'h30);
    push_pc(32'h34);
    push_pc(32'h38);
    repeat (6) push_pc(32'h3C);
    drain("run1_timeout");

    chk("x0",  dut.regs.regs[0],  32'h0000_0000);
    chk("x5",  dut.regs.regs[5],  32'h0000_0007);
    chk("x10", dut.regs.regs[10], 32'hFFFF_FFF0);
    chk("x6",  dut.regs.regs[6],  32'h0000_0000);
    chk("x7",  dut.regs.regs[7],  32'h0000_0000);
    chk("x8",  dut.regs.regs[8],  32'h0000_00F0);
    chk("x9",  dut.regs.regs[9],  32'h0000_0003);
    chk("x11", dut.regs.regs[11], 32'h0000_000F);
    chk("x12", dut.regs.regs[12], 32'h0000_0000);
    chk("x13", dut.regs.regs[13], 32'h0000_0055);
    chk("x14", dut.regs.regs[14], 32'h0000_0007);
    chk("x16", dut.regs.regs[16], 32'h0000_0077);
    chk("mem4", {24'd0, dut.datamem.mem[4]}, 32'h0000_000F);
    chk("mem5", {24'd0, dut.datamem.mem[5]}, 32'h0000_00AA);

    // Restart, then pulse reset while the ori at 0x10 is being fetched.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dut.regs.regs[8] = 32'h0000_0123;
    reset = 1'b1;
    for (int a = 0; a <= 32'h10; a += 4) push_pc(a);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    push_pc(32'h0);
    @(negedge clk);
    #2;
    chk("x8_discard", dut.regs.regs[8], 32'h0000_0123);
    reset = 1'b1;
    push_pc(32'h4);
    push_pc(32'h8);
    drain("run2_timeout");
    chk("x5_kept", dut.regs.regs[5], 32'h0000_0007);
    chk("mem4_kept", {24'd0, dut.datamem.mem[4]}, 32'h0000_000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
